serial_full_adder: RTL and testbench
====================================

// Module: serial_full_adder
// PURPOSE
//  Bit-serial adder built around the 1-bit full-adder cell. It accepts two
//  WIDTH-bit operands and a carry-in over a valid/ready handshake, then
//  processes one bit per clock, LSB first, through a full-adder plus a carry
//  register. It returns the WIDTH-bit sum and carry-out over a second
//  valid/ready handshake.
//  Sits between operand producers and result consumers where area matters
//  more than latency.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range WIDTH >= 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a/b/c_in valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry into bit 0
//  out_valid  out  1      sum/c_out valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  (a + b + c_in) mod 2^WIDTH
//  c_out      out  1      bit WIDTH of (a + b + c_in)
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is asynchronous and active-high.
//    While rst=1: state=IDLE, out_valid=0, sum=0, c_out=0, carry reg=0,
//    bit counter=0, in_ready=1.
//  - FSM states: IDLE, ADD, DONE. in_ready = (state==IDLE);
//    out_valid = (state==DONE). Both are decoded from registered state only.
//  - IDLE: on a clock edge with in_valid=1, the block:
//      * loads shift regs a_sh<=a and b_sh<=b;
//      * sets carry<=c_in and cnt<=0;
//      * moves to ADD.
//    If in_valid=0, it stays in IDLE.
//  - ADD, on each edge:
//      * s  = a_sh[0] ^ b_sh[0] ^ carry;
//      * co = majority(a_sh[0], b_sh[0], carry);
//      * sum_sh <= {s, sum_sh[WIDTH-1:1]};
//      * a_sh and b_sh shift right by 1;
//      * carry <= co and cnt <= cnt+1.
//    When cnt==WIDTH-1, the same edge moves to DONE and loads c_out<=co.
//  - ADD takes exactly WIDTH cycles. Operands accepted at edge k give
//    out_valid=1 after edge k+WIDTH.
//  - For WIDTH=1, ADD lasts a single cycle.
//  - cnt width: $clog2(WIDTH+1). cnt never wraps past WIDTH-1.
//  - DONE: sum and c_out hold stable while out_valid=1. On an edge with
//    out_ready=1, the block moves to IDLE. A new operand is accepted no
//    earlier than the following edge; there is no in/out overlap.
//  - in_valid during ADD/DONE is ignored, because in_ready=0. Upstream must
//    hold its operands until the handshake completes.
//  - out_ready is a don't-care outside DONE.
//  - sum and c_out are guaranteed only while out_valid=1.
//      * sum may change during ADD.
//      * c_out holds its previous result until DONE is entered.
//  - Arithmetic is unsigned with no overflow flag; c_out is the only
//    overflow indication.
//  - Reset mid-ADD or mid-DONE abandons the operation. No result is emitted,
//    and all outputs take their reset values immediately, asynchronously.
// TESTING
//  1. Reset: assert rst mid-ADD (WIDTH=8) -> out_valid=0, sum=8'h00,
//     c_out=0, in_ready=1 immediately; no out_valid after release.
//  2. a=8'h00, b=8'h00, c_in=1 -> sum=8'h01, c_out=0. out_valid rises
//     exactly 8 clocks after the accept edge.
//  3. Full ripple: a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1.
//  4. Max: a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
//  5. Backpressure: a=8'h3C, b=8'h1E, c_in=0, out_ready=0 for 5 cycles ->
//     sum=8'h5A and c_out=0 held, out_valid=1, in_ready=0. A concurrent
//     in_valid is not accepted. in_ready=1 one cycle after out_ready=1.
//  6. WIDTH=1, all 8 {a,b,c_in} combos -> {c_out,sum} matches the
//     full-adder truth table (e.g. 1,1,1 -> sum=1, c_out=1). Latency is
//     1 cycle.

Source files
------------

// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell plus a carry register, one bit per clock, LSB first.
// Operands come in over one valid/ready handshake and the result goes out over a second one.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic            carry;
  logic            c_out_r;
  logic [CW-1:0]   cnt;

  logic             s;
  logic             co;
  logic [WIDTH-1:0] sum_next;

  // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at index 0.
  always_comb begin
    s  = a_sh[0] ^ b_sh[0] ^ carry;
    co = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    sum_next = sum_sh >> 1;
    sum_next[WIDTH-1] = s;
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE and out_valid only in DONE, so input and output never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      c_out_r <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= co;
          if (cnt == LAST) begin
            c_out_r <= co;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_sh;
  assign c_out     = c_out_r;

endmodule

// File: tb/tb_serial_full_adder.sv
// Bench for serial_full_adder: directed cases, random traffic against a queue-based
// arithmetic model (WIDTH=8), and the full-adder truth table on a WIDTH=1 instance.
module tb_serial_full_adder;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;

  // WIDTH=1 instance
  logic w1_in_valid = 1'b0;
  logic w1_in_ready;
  logic w1_a = 1'b0;
  logic w1_b = 1'b0;
  logic w1_c_in = 1'b0;
  logic w1_out_valid;
  logic w1_out_ready = 1'b0;
  logic w1_sum;
  logic w1_c_out;

  serial_full_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out)
  );

  serial_full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .a(w1_a), .b(w1_b), .c_in(w1_c_in),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready),
    .sum(w1_sum), .c_out(w1_c_out)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is the number a+b+c_in, ready WIDTH edges after acceptance,
  // retired when the consumer takes it.
  logic [W:0] exp_q[$];
  bit m_busy  = 1'b0;
  bit m_valid = 1'b0;
  int m_rem   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_valid = 1'b0;
      m_rem = 0;
      exp_q.delete();
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        void'(exp_q.pop_front());
      end
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_valid = 1'b1;
      end
    end else if (in_valid) begin
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in});
      m_busy = 1'b1;
      m_rem = W;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model_in_ready", 32'(in_ready), 32'(!m_busy && !m_valid));
      check("model_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid && exp_q.size() > 0)
        check("model_result", 32'({c_out, sum}), 32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] exp_sum, input logic exp_co,
                        input int stall, input bit hold_valid);
    int n;
    @(negedge clk);
    a = av; b = bv; c_in = cv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (hold_valid) begin
      a = W'($urandom); b = W'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(W));
    check("sum", 32'(sum), 32'(exp_sum));
    check("c_out", 32'(c_out), 32'(exp_co));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_sum", 32'({c_out, sum}), 32'({exp_co, exp_sum}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("ready_after_accept", 32'(in_ready), 32'd1);
    check("valid_after_accept", 32'(out_valid), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_w1_in_ready", 32'(w1_in_ready), 32'd1);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset in the middle of an addition: outputs drop at once, no result afterwards.
    @(negedge clk);
    a = 8'hFF; b = 8'h00; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_sum", 32'(sum), 32'd0);
    check("async_c_out", 32'(c_out), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_result_after_rst", 32'(out_valid), 32'd0);
    end

    run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1, 1'b0);
    run_op(8'h3C, 8'h1E, 1'b0, 8'h5A, 1'b0, 5, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 2, 1'b0);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      c_in      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (W + 3) @(negedge clk);

    // WIDTH=1: full-adder truth table, one cycle in ADD.
    w1_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int ones;
      @(negedge clk);
      {w1_a, w1_b, w1_c_in} = 3'(k);
      w1_in_valid = 1'b1;
      ones = int'(w1_a) + int'(w1_b) + int'(w1_c_in);
      @(negedge clk);
      w1_in_valid = 1'b0;
      check("w1_busy_out_valid", 32'(w1_out_valid), 32'd0);
      check("w1_busy_in_ready", 32'(w1_in_ready), 32'd0);
      @(negedge clk);
      check("w1_out_valid", 32'(w1_out_valid), 32'd1);
      check("w1_sum", 32'(w1_sum), 32'(ones % 2));
      check("w1_c_out", 32'(w1_c_out), 32'(ones >= 2));
    end
    @(negedge clk);
    check("w1_idle", 32'(w1_in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
